uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receiver for the SoC peripheral bus; successor to the fixed 8N1 receiver.
- Adds programmable baud divisor, data width, optional parity, 1/2 stop bits, input synchronisation and 3-sample majority voting.
- Adds framing/parity/break/overrun detection and a valid/ready output register so the bus-side consumer can stall.
- Sits between the RX pad and the UART register block / RX FIFO.

Parameters:
DATA_BITS, 8, maximum data width; frames carry exactly DATA_BITS bits, LSB first (legal 5..9)
CNT_W, 16, width of the baud divisor and bit-period counter
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  synchronous active-low reset
i_data  input  1  asynchronous serial line, idle high
i_clks_per_bit  input  CNT_W  clocks per bit; values <4 are treated as 4
i_parity_en  input  1  1 = parity bit follows the data bits
i_parity_odd  input  1  1 = odd parity, 0 = even
i_two_stop  input  1  1 = two stop bits expected
o_data  output  DATA_BITS  received word
o_valid  output  1  o_data and flags are valid; held until accepted
i_ready  input  1  consumer accepts when o_valid && i_ready
o_parity_err  output  1  parity mismatch for the word in o_data
o_frame_err  output  1  a stop bit was sampled low for the word in o_data
o_break  output  1  break condition (all bits incl. parity/stop low); o_data = 0
o_overrun  output  1  sticky; set when a frame completes while the output is occupied; cleared by accept
o_busy  output  1  FSM not in IDLE

Behaviour:
- Reset (i_rst_n=0 on a clock edge): synchroniser all 1; FSM = IDLE; counters 0; o_data=0; o_valid, o_parity_err, o_frame_err, o_break, o_overrun = 0. Reset mid-frame abandons the frame with no output.
- Synchroniser: SYNC_STAGES flops reset to 1. The FSM sees only the synchronised line (rx_s).
- Majority sampling: the bit value is maj(rx_s at mid-1, mid, mid+1), where mid = (div-1)>>1 and div is the clamped divisor.
- Config latch: divisor, parity_en, parity_odd and two_stop are latched on the IDLE->START transition. Changes during a frame take effect on the next frame.
- FSM:
  - IDLE: on rx_s=0, go to START; cnt=0.
  - START: count to mid+1. If the majority is 0, go to DATA with cnt=0. Otherwise treat as a glitch and return to IDLE.
  - DATA: each bit takes div clocks and is sampled at mid+1. Bits shift in LSB first. After bit DATA_BITS-1, go to PARITY if parity_en, else STOP.
  - PARITY: sample one bit. Error when (XOR of data ^ sampled bit) != parity_odd.
  - STOP: sample stop bit 1; if two_stop, also sample stop bit 2 one period later. frame_err if any stop sample is 0. At the last stop sample go to DONE.
  - DONE: one cycle; commit to the output. If break, go to BRK, else go to IDLE.
  - BRK: wait until rx_s=1, then go to IDLE. No new start is detected while in BRK.
- Latency: o_valid rises 2 clocks after the mid+1 sample point of the final stop bit.
- Break: data=0, parity sample (if enabled)=0 and all stop samples=0. Then o_break=1, o_frame_err=1, o_parity_err=0, o_data=0.
- Output register:
  - Commit in DONE when !o_valid, or when o_valid && i_ready in that same cycle. Simultaneous accept and commit loads the new word with no overrun.
  - If o_valid && !i_ready in DONE: the new frame is dropped, the old word and flags are kept, and o_overrun is set.
  - Accept (o_valid && i_ready) without a commit clears o_valid, o_overrun and all flags.
- Counter: cnt is CNT_W bits and never wraps within a bit (it resets at div-1). A divisor of 2^CNT_W-1 is legal.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, DONE, BRK) and its encoding width;
  - MIN_DIV=4;
  - the parity function (data, odd) -> expected bit.
- Sub-module uart_rx_sampler: synchroniser, bit-period counter and 3-tap majority. It issues a sample strobe and voted bit to the FSM.
- The FSM and output register stay in uart_rx_cfg.

Test Plan:
- 8N1, div=8: send 0xA5 with i_ready=1 -> o_valid 1 cycle, o_data=0xA5, all flags 0.
- 8E2, div=16: send 0x3C with correct parity 0 -> data 0x3C, no errors. Resend with the parity bit flipped -> o_parity_err=1.
- 8N1, div=8: 0x55 with stop bit driven low -> o_frame_err=1, o_data=0x55. Then line held low for 20 bit periods -> o_break=1, o_data=0. No further o_valid until the line goes high and a new start bit arrives.
- i_ready=0: send 0x11 then 0x22 -> o_data stays 0x11 and o_overrun=1. Raise i_ready -> accept clears o_valid and o_overrun; 0x22 is never delivered.
- Glitch rejection, div=16: a 3-clock low pulse on an idle line -> FSM returns to IDLE, no o_valid. A single-clock spike mid-bit inside a valid 0xF0 frame -> still 0xF0.
- Reset mid-frame (i_rst_n=0 for 1 cycle during DATA): all outputs 0, FSM IDLE. The next clean frame 0x81 is received correctly. i_clks_per_bit=2 -> behaves as div=4.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
// State encoding, minimum divisor and parity helper.
package uart_pkg;

  localparam int STATE_W = 3;
  localparam int MIN_DIV = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    BRK
  } state_e;

  // Expected parity bit for a zero-extended data word.
  function automatic logic par_bit(
    input logic [15:0] data,
    input logic        odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX synchroniser, bit-period counter and 3-tap majority voter.
// Strobes o_strobe with the voted bit at count mid+1.
module uart_rx_sampler #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_data,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_run,
  input  logic             i_clr,
  output logic             o_rx_s,
  output logic             o_strobe,
  output logic             o_bit
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             hist_q, hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       mid;

  assign o_rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_data};
    hist_d = {hist_q[0], o_rx_s};
    mid    = (i_div - 1'b1) >> 1;
    // Wrap at div-1 so the counter never overflows inside a bit.
    if (!i_run || i_clr) begin
      cnt_d = '0;
    end else if (cnt_q == i_div - 1'b1) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    o_strobe = i_run && (cnt_q == mid + 1'b1);
    o_bit    = (hist_q[1] & hist_q[0]) |
               (hist_q[1] & o_rx_s)    |
               (hist_q[0] & o_rx_s);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= '1;
      hist_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with error flags and
// a valid/ready output register.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_data,
  input  logic [CNT_W-1:0]     i_clks_per_bit,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_two_stop,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int IDX_W = $clog2(DATA_BITS);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     div_q, div_d;
  logic                 pen_q, pen_d;
  logic                 podd_q, podd_d;
  logic                 two_q, two_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop2_q, stop2_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 hi_q, hi_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 operr_q, operr_d;
  logic                 oferr_q, oferr_d;
  logic                 obrk_q, obrk_d;
  logic                 ovr_q, ovr_d;

  logic                 rx_s, strobe, vbit;
  logic                 run, clr, brk;
  logic                 accept, commit;
  logic [CNT_W-1:0]     div_in;

  uart_rx_sampler #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_data   (i_data),
    .i_div    (div_q),
    .i_run    (run),
    .i_clr    (clr),
    .o_rx_s   (rx_s),
    .o_strobe (strobe),
    .o_bit    (vbit)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    pen_d   = pen_q;
    podd_d  = podd_q;
    two_d   = two_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    stop2_d = stop2_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    hi_d    = hi_q;
    clr     = 1'b0;
    div_in  = (i_clks_per_bit < CNT_W'(MIN_DIV)) ?
              CNT_W'(MIN_DIV) : i_clks_per_bit;
    run     = (state_q == START) || (state_q == DATA) ||
              (state_q == PARITY) || (state_q == STOP);
    // Break: all data, parity and stop samples were low.
    brk     = (sh_q == '0) && !hi_q;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          div_d   = div_in;
          pen_d   = i_parity_en;
          podd_d  = i_parity_odd;
          two_d   = i_two_stop;
        end
      end
      START: begin
        if (strobe) begin
          clr = 1'b1;
          if (!vbit) begin
            state_d = DATA;
            idx_d   = '0;
            stop2_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            hi_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (strobe) begin
          sh_d  = {vbit, sh_q[DATA_BITS-1:1]};
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = pen_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (strobe) begin
          hi_d    = hi_q | vbit;
          perr_d  = vbit != par_bit(16'(sh_q), podd_q);
          state_d = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          ferr_d = ferr_q | ~vbit;
          hi_d   = hi_q | vbit;
          if (two_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = brk ? BRK : IDLE;
      BRK:     if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    operr_d = operr_q;
    oferr_d = oferr_q;
    obrk_d  = obrk_q;
    ovr_d   = ovr_q;
    accept  = valid_q && i_ready;
    commit  = (state_q == DONE) && (!valid_q || i_ready);
    if (commit) begin
      data_d  = brk ? '0 : sh_q;
      valid_d = 1'b1;
      operr_d = perr_q && !brk;
      oferr_d = ferr_q;
      obrk_d  = brk;
      ovr_d   = 1'b0;
    end else if (accept) begin
      valid_d = 1'b0;
      operr_d = 1'b0;
      oferr_d = 1'b0;
      obrk_d  = 1'b0;
      ovr_d   = 1'b0;
    end else if (state_q == DONE) begin
      ovr_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      div_q   <= CNT_W'(MIN_DIV);
      pen_q   <= 1'b0;
      podd_q  <= 1'b0;
      two_q   <= 1'b0;
      sh_q    <= '0;
      idx_q   <= '0;
      stop2_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      hi_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
      obrk_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pen_q   <= pen_d;
      podd_q  <= podd_d;
      two_q   <= two_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      stop2_q <= stop2_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      operr_q <= operr_d;
      oferr_q <= oferr_d;
      obrk_q  <= obrk_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = operr_q;
  assign o_frame_err  = oferr_q;
  assign o_break      = obrk_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed scenarios plus random
// frames decoded by a bit-level reference model.
module tb_uart_rx_cfg;

  localparam int DB = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxd = 1'b1;
  logic [CW-1:0] cpb = 16'd8;
  logic          pen = 1'b0;
  logic          podd = 1'b0;
  logic          two = 1'b0;
  logic          rdy = 1'b1;
  logic [DB-1:0] dout;
  logic          vld, perr, ferr, brk, ovr, busy;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .DATA_BITS   (DB),
    .CNT_W       (CW),
    .SYNC_STAGES (2)
  ) u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_data         (rxd),
    .i_clks_per_bit (cpb),
    .i_parity_en    (pen),
    .i_parity_odd   (podd),
    .i_two_stop     (two),
    .o_data         (dout),
    .o_valid        (vld),
    .i_ready        (rdy),
    .o_parity_err   (perr),
    .o_frame_err    (ferr),
    .o_break        (brk),
    .o_overrun      (ovr),
    .o_busy         (busy)
  );

  function automatic logic [31:0] rec(
    input logic o, input logic b,
    input logic f, input logic p,
    input logic [DB-1:0] d
  );
    return {20'd0, o, b, f, p, d};
  endfunction

  always @(negedge clk)
    if (rst_n && vld && rdy)
      got_q.push_back(rec(ovr, brk, ferr, perr, dout));

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Decode a serial frame (start, data, parity?, stops).
  function automatic logic [31:0] ref_decode(
    input bit b[$], input bit pe,
    input bit po, input bit ts
  );
    logic [DB-1:0] d;
    int  k, ones;
    bit  any_hi, fe, pe_err, bk;
    any_hi = 0;
    fe = 0;
    pe_err = 0;
    for (int i = 0; i < DB; i++) d[i] = b[1 + i];
    k = 1 + DB;
    if (pe) begin
      ones = $countones(d) + int'(b[k]);
      pe_err = po ? (ones % 2 == 0) : (ones % 2 == 1);
      if (b[k]) any_hi = 1;
      k++;
    end
    for (int s = 0; s < (ts ? 2 : 1); s++) begin
      if (b[k]) any_hi = 1;
      else fe = 1;
      k++;
    end
    bk = (d == '0) && !any_hi;
    return rec(0, bk, fe, bk ? 1'b0 : pe_err,
               bk ? '0 : d);
  endfunction

  task automatic send(
    input logic [DB-1:0] d,
    input bit flip,
    input bit stop0,
    input int spike,
    input bit tail_low
  );
    bit b[$];
    int div;
    logic [CW-1:0] s_cpb;
    logic s_pen, s_podd, s_two;
    div = (cpb < 4) ? 4 : int'(cpb);
    b.push_back(1'b0);
    for (int i = 0; i < DB; i++) b.push_back(d[i]);
    if (pen) begin
      if ($countones(d) % 2 == 0) b.push_back(podd ^ flip);
      else b.push_back(~podd ^ flip);
    end
    b.push_back(~stop0);
    if (two) b.push_back(1'b1);
    exp_q.push_back(ref_decode(b, pen, podd, two));
    s_cpb = cpb;
    s_pen = pen;
    s_podd = podd;
    s_two = two;
    foreach (b[i]) begin
      if (i == 1) begin
        // Config changes mid-frame must not take effect.
        cpb = 16'($urandom_range(1, 40));
        pen = 1'($urandom);
        podd = 1'($urandom);
        two = 1'($urandom);
      end
      rxd = b[i];
      if (i == spike) begin
        tick(div / 2);
        rxd = ~b[i];
        tick(1);
        rxd = b[i];
        tick(div - div / 2 - 1);
      end else begin
        tick(div);
      end
    end
    cpb = s_cpb;
    pen = s_pen;
    podd = s_podd;
    two = s_two;
    if (tail_low) begin
      rxd = 1'b0;
      tick(20 * div);
      exp_q.push_back(rec(0, 1, 1, 0, '0));
    end
    rxd = 1'b1;
    tick(2 * div);
  endtask

  task automatic drain(input string tag);
    logic [31:0] e, g;
    check({tag, "_cnt"}, 32'(got_q.size()),
          32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front()
                             : 32'hffff_ffff;
      check(tag, g, e);
    end
    got_q.delete();
  endtask

  initial begin
    int raw;
    tick(3);
    check("rst_valid", 32'(vld), 0);
    check("rst_data", 32'(dout), 0);
    check("rst_flags", {28'd0, perr, ferr, brk, ovr}, 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick(5);

    cpb = 16'd8;
    send(8'hA5, 0, 0, -1, 0);
    drain("8n1_a5");

    cpb = 16'd16;
    pen = 1'b1;
    podd = 1'b0;
    two = 1'b1;
    send(8'h3C, 0, 0, -1, 0);
    send(8'h3C, 1, 0, -1, 0);
    drain("8e2_3c");

    cpb = 16'd8;
    pen = 1'b0;
    two = 1'b0;
    send(8'h55, 0, 1, -1, 1);
    drain("ferr_brk");
    send(8'h5A, 0, 0, -1, 0);
    drain("after_brk");

    rdy = 1'b0;
    send(8'h11, 0, 0, -1, 0);
    send(8'h22, 0, 0, -1, 0);
    check("ovr_valid", 32'(vld), 1);
    check("ovr_data", 32'(dout), 32'h11);
    check("ovr_flag", 32'(ovr), 1);
    exp_q.delete();
    exp_q.push_back(rec(1, 0, 0, 0, 8'h11));
    rdy = 1'b1;
    tick(1);
    check("acc_valid", 32'(vld), 0);
    check("acc_ovr", 32'(ovr), 0);
    drain("ovr");

    cpb = 16'd16;
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(40);
    check("glitch_busy", 32'(busy), 0);
    drain("glitch");
    send(8'hF0, 0, 0, 4, 0);
    drain("spike_f0");

    cpb = 16'd2;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(4);
    rxd = 1'b0;
    tick(4);
    rst_n = 1'b0;
    rxd = 1'b1;
    tick(1);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_out", {23'd0, vld, dout}, 0);
    rst_n = 1'b1;
    tick(20);
    send(8'h81, 0, 0, -1, 0);
    drain("div2_81");

    for (int n = 0; n < 40; n++) begin
      raw = $urandom_range(1, 20);
      cpb = 16'(raw);
      pen = 1'($urandom);
      podd = 1'($urandom);
      two = 1'($urandom);
      send(8'($urandom), pen && ($urandom_range(0, 3) == 0),
           0, -1, 0);
      drain("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
